addr_burst_reg: RTL and testbench

- Parametrised successor of the team's loadable address register.
- Holds an A-bit address that can be loaded directly, as before.
- Adds a burst engine: on `start` it steps the address by a programmable stride, up or down, once per accepted beat, for `len` beats.
- Optional wrap is within a [lo_lim, hi_lim] window. Used by memory/DMA-style sequencers to generate address streams.

---
 rtl/addr_burst_pkg.sv | 17 +
 rtl/addr_burst_reg_if.sv | 37 +++
 rtl/addr_step.sv | 64 ++++++
 rtl/addr_burst_reg.sv | 126 ++++++++++++
 tb/tb_addr_burst_reg.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/addr_burst_pkg.sv
// Shared types and constants for the burst address register.
// Contents: FSM state enum, default widths, direction encodings.
package addr_burst_pkg;

   localparam int unsigned DEF_A = 8;  // address/data width
   localparam int unsigned DEF_S = 4;  // stride width
   localparam int unsigned DEF_L = 8;  // burst-length width

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/addr_burst_reg_if.sv
// Bus bundle for addr_burst_reg.
// master: drives load/burst controls and beat accept, observes address and status.
// slave : the register itself.
interface addr_burst_reg_if
   import addr_burst_pkg::*;
#(
   parameter int unsigned A = DEF_A,
   parameter int unsigned S = DEF_S,
   parameter int unsigned L = DEF_L
) ();

   logic         select;
   logic [A-1:0] data;
   logic         start;
   logic [L-1:0] len;
   logic [S-1:0] stride;
   logic         dir;
   logic         wrap_en;
   logic [A-1:0] lo_lim;
   logic [A-1:0] hi_lim;
   logic         adv;
   logic [A-1:0] q;
   logic         busy;
   logic         done;
   logic         wrapped;

   modport master (
      output select, data, start, len, stride, dir, wrap_en, lo_lim, hi_lim, adv,
      input  q, busy, done, wrapped
   );

   modport slave (
      input  select, data, start, len, stride, dir, wrap_en, lo_lim, hi_lim, adv,
      output q, busy, done, wrapped
   );

endinterface

// File: rtl/addr_step.sv
// Combinational address stepper.
// Inputs : q (current address), stride, dir, wrap_en, lo_lim/hi_lim (inclusive window).
// Outputs: next_q (address after one step), wrap (window wrap, carry-out or borrow).
module addr_step
   import addr_burst_pkg::*;
#(
   parameter int unsigned A = DEF_A,
   parameter int unsigned S = DEF_S
) (
   input  logic [A-1:0] q,
   input  logic [S-1:0] stride,
   input  logic         dir,
   input  logic         wrap_en,
   input  logic [A-1:0] lo_lim,
   input  logic [A-1:0] hi_lim,
   output logic [A-1:0] next_q,
   output logic         wrap
);

   localparam int unsigned W = A + 1;

   logic [A:0] n;
   logic       win_ok;

   always_comb begin
      next_q = q;
      wrap   = 1'b0;
      n      = '0;
      // An inverted window is treated as no window at all.
      win_ok = wrap_en && (lo_lim <= hi_lim);
      // Zero stride never moves and never flags a wrap, even if q sits outside the window.
      if (stride != '0) begin
         if (dir == DIR_UP) begin
            n = {1'b0, q} + W'(stride);
            if (win_ok) begin
               if (n > {1'b0, hi_lim}) begin
                  next_q = lo_lim;
                  wrap   = 1'b1;
               end else begin
                  next_q = n[A-1:0];
               end
            end else begin
               next_q = n[A-1:0];
               wrap   = n[A];
            end
         end else begin
            n = {1'b0, q} - W'(stride);
            if (win_ok) begin
               // n[A] is the borrow: result went below zero, hence below lo_lim.
               if (n[A] || (n[A-1:0] < lo_lim)) begin
                  next_q = hi_lim;
                  wrap   = 1'b1;
               end else begin
                  next_q = n[A-1:0];
               end
            end else begin
               next_q = n[A-1:0];
               wrap   = n[A];
            end
         end
      end
   end

endmodule

// File: rtl/addr_burst_reg.sv
// Loadable address register with a burst engine.
// Ports: clk, reset (async, active-high), bus (slave side of addr_burst_reg_if).
// select loads data (and aborts a burst); start launches a len-beat burst that steps q
// by stride on every adv, optionally wrapping inside [lo_lim, hi_lim].
// busy is high in RUN; done and wrapped are one-cycle registered pulses.
module addr_burst_reg
   import addr_burst_pkg::*;
#(
   parameter int unsigned A = DEF_A,
   parameter int unsigned S = DEF_S,
   parameter int unsigned L = DEF_L
) (
   input logic                clk,
   input logic                reset,
   addr_burst_reg_if.slave    bus
);

   state_e       state_q, state_d;
   logic [L-1:0] cnt_q, cnt_d;
   logic [S-1:0] stride_q, stride_d;
   logic         dir_q, dir_d;
   logic         wrap_en_q, wrap_en_d;
   logic [A-1:0] lo_q, lo_d;
   logic [A-1:0] hi_q, hi_d;
   logic [A-1:0] q_q, q_d;
   logic         done_q, done_d;
   logic         wrapped_q, wrapped_d;

   logic [A-1:0] step_q;
   logic         step_wrap;

   // Steps from the captured burst config, never from the live inputs.
   addr_step #(
      .A (A),
      .S (S)
   ) u_step (
      .q       (q_q),
      .stride  (stride_q),
      .dir     (dir_q),
      .wrap_en (wrap_en_q),
      .lo_lim  (lo_q),
      .hi_lim  (hi_q),
      .next_q  (step_q),
      .wrap    (step_wrap)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stride_d  = stride_q;
      dir_d     = dir_q;
      wrap_en_d = wrap_en_q;
      lo_d      = lo_q;
      hi_d      = hi_q;
      q_d       = q_q;
      done_d    = 1'b0;
      wrapped_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.select) begin
               q_d = bus.data;
            end else if (bus.start) begin
               if (bus.len == '0) begin
                  done_d = 1'b1;
               end else begin
                  cnt_d     = bus.len;
                  stride_d  = bus.stride;
                  dir_d     = bus.dir;
                  wrap_en_d = bus.wrap_en;
                  lo_d      = bus.lo_lim;
                  hi_d      = bus.hi_lim;
                  state_d   = RUN;
               end
            end
         end
         RUN: begin
            if (bus.select) begin
               // Abort: load wins over any beat, no done pulse.
               q_d     = bus.data;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (bus.adv) begin
               q_d       = step_q;
               wrapped_d = step_wrap;
               cnt_d     = cnt_q - L'(1);
               if (cnt_q == L'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         stride_q  <= '0;
         dir_q     <= DIR_UP;
         wrap_en_q <= 1'b0;
         lo_q      <= '0;
         hi_q      <= '0;
         q_q       <= '0;
         done_q    <= 1'b0;
         wrapped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         stride_q  <= stride_d;
         dir_q     <= dir_d;
         wrap_en_q <= wrap_en_d;
         lo_q      <= lo_d;
         hi_q      <= hi_d;
         q_q       <= q_d;
         done_q    <= done_d;
         wrapped_q <= wrapped_d;
      end
   end

   assign bus.q       = q_q;
   assign bus.busy    = (state_q == RUN);
   assign bus.done    = done_q;
   assign bus.wrapped = wrapped_q;

endmodule

// File: tb/tb_addr_burst_reg.sv
// Self-checking bench for addr_burst_reg: directed scenarios plus random traffic,
// with a queue-based scoreboard fed by a behavioural model.
module tb_addr_burst_reg;

   localparam int unsigned A = 8;
   localparam int unsigned S = 4;
   localparam int unsigned L = 8;
   localparam int MOD = 1 << A;

   logic clk;
   logic reset;

   addr_burst_reg_if #(.A(A), .S(S), .L(L)) bus ();

   addr_burst_reg #(.A(A), .S(S), .L(L)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int q;
      bit busy;
      bit done;
      bit wrapped;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Model state: plain integers, following the behavioural rules.
   int m_q, m_left, m_stride, m_lo, m_hi;
   bit m_run, m_dir, m_wrap_en, m_done, m_wr;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_step();
      int  n;
      bit  win;
      win = m_wrap_en && (m_lo <= m_hi);
      if (m_stride == 0) return;
      if (!m_dir) begin
         n = m_q + m_stride;
         if (win && n > m_hi) begin
            m_q = m_lo; m_wr = 1;
         end else if (n >= MOD) begin
            m_q = n - MOD; m_wr = 1;
         end else begin
            m_q = n;
         end
      end else begin
         n = m_q - m_stride;
         if (win && n < m_lo) begin
            m_q = m_hi; m_wr = 1;
         end else if (n < 0) begin
            m_q = n + MOD; m_wr = 1;
         end else begin
            m_q = n;
         end
      end
   endfunction

   // Advance the model across one rising edge using the current inputs.
   function automatic void model_edge();
      m_done = 0;
      m_wr   = 0;
      if (reset) begin
         m_q = 0; m_left = 0; m_run = 0; m_stride = 0; m_dir = 0;
         m_wrap_en = 0; m_lo = 0; m_hi = 0;
      end else if (!m_run) begin
         if (bus.select) begin
            m_q = int'(bus.data);
         end else if (bus.start) begin
            if (bus.len == 0) begin
               m_done = 1;
            end else begin
               m_left = int'(bus.len); m_stride = int'(bus.stride); m_dir = bus.dir;
               m_wrap_en = bus.wrap_en; m_lo = int'(bus.lo_lim); m_hi = int'(bus.hi_lim);
               m_run = 1;
            end
         end
      end else begin
         if (bus.select) begin
            m_q = int'(bus.data); m_left = 0; m_run = 0;
         end else if (bus.adv) begin
            model_step();
            m_left--;
            if (m_left == 0) begin
               m_run = 0; m_done = 1;
            end
         end
      end
   endfunction

   // Called just after a falling edge with inputs set; returns at the next falling edge.
   task automatic cycle();
      exp_t e;
      model_edge();
      e.q = m_q; e.busy = m_run; e.done = m_done; e.wrapped = m_wr;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: pops one expectation per rising edge and compares.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_q", int'(bus.q), e.q);
            check("sb_busy", int'(bus.busy), int'(e.busy));
            check("sb_done", int'(bus.done), int'(e.done));
            check("sb_wrapped", int'(bus.wrapped), int'(e.wrapped));
         end
      end
   end

   task automatic idle_inputs();
      bus.select = 0; bus.data = '0; bus.start = 0; bus.len = '0; bus.stride = '0;
      bus.dir = 0; bus.wrap_en = 0; bus.lo_lim = '0; bus.hi_lim = '0; bus.adv = 0;
   endtask

   task automatic load(input int d);
      bus.select = 1; bus.data = A'(d);
      cycle();
      bus.select = 0;
   endtask

   task automatic launch(input int n, input int st, input bit dr, input bit we,
                         input int lo, input int hi);
      bus.start = 1; bus.len = L'(n); bus.stride = S'(st); bus.dir = dr;
      bus.wrap_en = we; bus.lo_lim = A'(lo); bus.hi_lim = A'(hi);
      cycle();
      bus.start = 0;
   endtask

   task automatic beats(input int n);
      bus.adv = 1;
      repeat (n) cycle();
      bus.adv = 0;
   endtask

   initial begin
      int r;
      idle_inputs();
      reset = 1;
      cycle();
      cycle();
      reset = 0;

      // Async reset mid-burst.
      load(8'h40);
      launch(4, 1, 0, 0, 0, 0);
      beats(2);
      #2 reset = 1;
      #1;
      check("rst_q", int'(bus.q), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_wrapped", int'(bus.wrapped), 0);
      @(negedge clk);
      cycle();
      reset = 0;

      // Load then up-burst.
      load(8'h10);
      launch(3, 2, 0, 0, 0, 0);
      check("up_first", int'(bus.q), 8'h10);
      beats(3);
      check("up_last", int'(bus.q), 8'h16);
      check("up_done", int'(bus.done), 1);
      cycle();
      check("up_done_clr", int'(bus.done), 0);

      // Window wrap up.
      load(8'h1E);
      launch(2, 4, 0, 1, 8'h10, 8'h1F);
      beats(1);
      check("win_q", int'(bus.q), 8'h10);
      check("win_wrapped", int'(bus.wrapped), 1);
      beats(1);
      check("win_q2", int'(bus.q), 8'h14);
      cycle();

      // Down with borrow, no window.
      load(8'h02);
      launch(1, 3, 1, 0, 0, 0);
      beats(1);
      check("dn_q", int'(bus.q), 8'hFF);
      check("dn_wrapped", int'(bus.wrapped), 1);
      check("dn_done", int'(bus.done), 1);
      cycle();

      // Stall, ignored start, abort.
      load(8'h20);
      launch(5, 1, 0, 0, 0, 0);
      beats(1);
      cycle();
      bus.start = 1; bus.len = 8'd1; bus.stride = 4'd7;
      cycle();
      bus.start = 0;
      beats(1);
      check("stall_q", int'(bus.q), 8'h22);
      bus.select = 1; bus.data = 8'hAA; bus.adv = 1;
      cycle();
      bus.select = 0; bus.adv = 0;
      check("abort_q", int'(bus.q), 8'hAA);
      check("abort_busy", int'(bus.busy), 0);
      cycle();
      check("abort_nodone", int'(bus.done), 0);

      // len = 0, stride = 0, select+start.
      launch(0, 3, 0, 0, 0, 0);
      check("len0_done", int'(bus.done), 1);
      check("len0_busy", int'(bus.busy), 0);
      launch(3, 0, 0, 1, 8'h00, 8'h10);
      beats(3);
      check("st0_q", int'(bus.q), 8'hAA);
      check("st0_done", int'(bus.done), 1);
      bus.select = 1; bus.data = 8'h55;
      launch(4, 1, 0, 0, 0, 0);
      bus.select = 0;
      check("selstart_q", int'(bus.q), 8'h55);
      check("selstart_busy", int'(bus.busy), 0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         bus.select  = ($urandom_range(0, 15) == 0);
         bus.data    = A'($urandom);
         bus.start   = ($urandom_range(0, 3) == 0);
         bus.len     = L'($urandom_range(0, 6));
         bus.stride  = S'($urandom);
         bus.dir     = 1'($urandom);
         bus.wrap_en = 1'($urandom);
         bus.lo_lim  = A'($urandom);
         r = int'(bus.lo_lim) + int'($urandom_range(0, 60));
         if ($urandom_range(0, 3) == 0) bus.hi_lim = A'($urandom);
         else bus.hi_lim = A'((r > MOD - 1) ? MOD - 1 : r);
         bus.adv     = 1'($urandom);
         cycle();
      end
      idle_inputs();
      cycle();

      check("sb_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
